// File: rtl/als_err_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : als_err_monitor_if
// Description : Sample stream {A, B, approximate sum} with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface als_err_monitor_if #(
    parameter int WIDTH = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_in0;
    logic [WIDTH-1:0] s_in1;
    logic [WIDTH:0]   s_out;

    modport master (output s_valid, s_in0, s_in1, s_out, input s_ready);
    modport slave  (input s_valid, s_in0, s_in1, s_out, output s_ready);
endinterface
`default_nettype wire

// File: rtl/als_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : als_err_monitor
// Description : Streaming error-metric collector for an approximate adder.
// Revision    : 1.0 - initial release
// ============================================================================
module als_err_monitor #(
    parameter int WIDTH   = 16,
    parameter int NSAMP_W = 20,
    parameter int SUM_W   = 40
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [NSAMP_W-1:0] num_samples,
    als_err_monitor_if.slave        s,
    output logic [NSAMP_W-1:0]      err_count,
    output logic [WIDTH:0]          max_ed,
    output logic [SUM_W-1:0]        sum_ed,
    output logic [NSAMP_W-1:0]      samples_done,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               s_ready_q, s_ready_d;
    logic [NSAMP_W-1:0] target_q, target_d;
    logic [NSAMP_W-1:0] acc_cnt_q, acc_cnt_d;

    logic               v1_q, v2_q;
    logic [WIDTH:0]     exact_q, approx_q, ed_q;

    logic [NSAMP_W-1:0] samples_done_q, samples_done_d;
    logic [NSAMP_W-1:0] err_count_q, err_count_d;
    logic [WIDTH:0]     max_ed_q, max_ed_d;
    logic [SUM_W-1:0]   sum_ed_q, sum_ed_d;

    logic               w_xfer;
    logic               w_clr;
    logic [WIDTH:0]     w_exact;
    logic [WIDTH:0]     w_ed;
    logic [SUM_W:0]     w_sum_ext;
    logic [NSAMP_W-1:0] w_acc_next;
    logic [NSAMP_W-1:0] w_done_next;

    assign w_xfer      = s.s_valid & s_ready_q;
    assign w_exact     = {1'b0, s.s_in0} + {1'b0, s.s_in1};
    assign w_ed        = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);
    assign w_sum_ext   = {1'b0, sum_ed_q} + {{(SUM_W - WIDTH){1'b0}}, ed_q};
    assign w_acc_next  = acc_cnt_q + NSAMP_W'(1);
    assign w_done_next = samples_done_q + NSAMP_W'(v2_q);

    // Control FSM: start is only honoured when no run is in flight.
    always_comb begin
        state_d   = state_q;
        s_ready_d = s_ready_q;
        target_d  = target_q;
        acc_cnt_d = acc_cnt_q;
        w_clr     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clr     = 1'b1;
                    target_d  = num_samples;
                    acc_cnt_d = '0;
                    if (num_samples == '0) begin
                        state_d   = ST_DONE;
                        s_ready_d = 1'b0;
                    end else begin
                        state_d   = ST_RUN;
                        s_ready_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    acc_cnt_d = w_acc_next;
                    if (w_acc_next == target_q) begin
                        s_ready_d = 1'b0;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that retires the final sample.
                if (w_done_next == target_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        samples_done_d = samples_done_q;
        err_count_d    = err_count_q;
        max_ed_d       = max_ed_q;
        sum_ed_d       = sum_ed_q;
        if (w_clr) begin
            samples_done_d = '0;
            err_count_d    = '0;
            max_ed_d       = '0;
            sum_ed_d       = '0;
        end else if (v2_q) begin
            samples_done_d = samples_done_q + NSAMP_W'(1);
            err_count_d    = err_count_q + NSAMP_W'(ed_q != '0);
            if (ed_q > max_ed_q) begin
                max_ed_d = ed_q;
            end
            sum_ed_d = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            s_ready_q      <= 1'b0;
            target_q       <= '0;
            acc_cnt_q      <= '0;
            v1_q           <= 1'b0;
            v2_q           <= 1'b0;
            exact_q        <= '0;
            approx_q       <= '0;
            ed_q           <= '0;
            samples_done_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
        end else begin
            state_q        <= state_d;
            s_ready_q      <= s_ready_d;
            target_q       <= target_d;
            acc_cnt_q      <= acc_cnt_d;
            v1_q           <= w_xfer;
            if (w_xfer) begin
                exact_q  <= w_exact;
                approx_q <= s.s_out;
            end
            v2_q           <= v1_q & ~w_clr;
            if (v1_q) begin
                ed_q <= w_ed;
            end
            samples_done_q <= samples_done_d;
            err_count_q    <= err_count_d;
            max_ed_q       <= max_ed_d;
            sum_ed_q       <= sum_ed_d;
        end
    end

    assign s.s_ready    = s_ready_q;
    assign err_count    = err_count_q;
    assign max_ed       = max_ed_q;
    assign sum_ed       = sum_ed_q;
    assign samples_done = samples_done_q;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_als_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_als_err_monitor
// Description : Self-checking bench; two monitors (40-bit and 17-bit sums).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_als_err_monitor;
    localparam int W   = 16;
    localparam int NW  = 20;
    localparam int SW  = 40;
    localparam int SWB = 17;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] num_samples = '0;

    always #5 clk = ~clk;

    als_err_monitor_if #(.WIDTH(W)) if_a ();
    als_err_monitor_if #(.WIDTH(W)) if_b ();

    assign if_b.s_valid = if_a.s_valid;
    assign if_b.s_in0   = if_a.s_in0;
    assign if_b.s_in1   = if_a.s_in1;
    assign if_b.s_out   = if_a.s_out;

    logic [NW-1:0]  a_err, a_sd, b_err, b_sd;
    logic [W:0]     a_max, b_max;
    logic [SW-1:0]  a_sum;
    logic [SWB-1:0] b_sum;
    logic           a_busy, a_done, b_busy, b_done;

    als_err_monitor #(.WIDTH(W), .NSAMP_W(NW), .SUM_W(SW)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .s(if_a.slave),
        .err_count(a_err), .max_ed(a_max), .sum_ed(a_sum), .samples_done(a_sd),
        .busy(a_busy), .done(a_done));

    als_err_monitor #(.WIDTH(W), .NSAMP_W(NW), .SUM_W(SWB)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .s(if_b.slave),
        .err_count(b_err), .max_ed(b_max), .sum_ed(b_sum), .samples_done(b_sd),
        .busy(b_busy), .done(b_done));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ed_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] o);
        int d;
        d = (int'(a) + int'(b)) - int'(o);
        return (d < 0) ? -d : d;
    endfunction

    // Reference: list of accepted samples tagged with their acceptance edge.
    bit m_run = 0;
    int m_target = 0;
    int m_nacc = 0;
    int m_acc_cyc[$];
    int m_acc_ed[$];
    int cyc = 0;

    always @(negedge clk) begin
        int ec, mx, vis;
        longint sm, sm_b;
        bit e_ready, e_done, e_busy;
        if (!rst_n) begin
            m_run = 0; m_target = 0; m_nacc = 0;
            m_acc_cyc.delete(); m_acc_ed.delete();
        end
        ec = 0; mx = 0; sm = 0; vis = 0;
        if (m_run) begin
            foreach (m_acc_cyc[i]) begin
                if (m_acc_cyc[i] <= cyc - 2) begin
                    vis++;
                    if (m_acc_ed[i] != 0) ec++;
                    if (m_acc_ed[i] > mx) mx = m_acc_ed[i];
                    sm += longint'(m_acc_ed[i]);
                end
            end
        end
        sm_b    = (sm > 64'h1FFFF) ? 64'h1FFFF : sm;
        e_ready = m_run && (m_nacc < m_target);
        e_done  = m_run && (m_nacc == m_target) &&
                  ((m_target == 0) || (m_acc_cyc[m_nacc-1] <= cyc - 2));
        e_busy  = m_run && !e_done;

        chk("ready",    64'(if_a.s_ready), 64'(e_ready));
        chk("ready_b",  64'(if_b.s_ready), 64'(e_ready));
        chk("busy",     64'(a_busy), 64'(e_busy));
        chk("done",     64'(a_done), 64'(e_done));
        chk("done_b",   64'(b_done), 64'(e_done));
        chk("err",      64'(a_err), 64'(ec));
        chk("max",      64'(a_max), 64'(mx));
        chk("sum",      64'(a_sum), 64'(sm));
        chk("sd",       64'(a_sd), 64'(vis));
        chk("sum_b",    64'(b_sum), 64'(sm_b));
        chk("sd_b",     64'(b_sd), 64'(vis));

        if (rst_n) begin
            if (if_a.s_valid && e_ready) begin
                m_acc_cyc.push_back(cyc + 1);
                m_acc_ed.push_back(ed_of(if_a.s_in0, if_a.s_in1, if_a.s_out));
                m_nacc++;
            end
            if (start && (!m_run || e_done)) begin
                m_run = 1; m_target = int'(num_samples); m_nacc = 0;
                m_acc_cyc.delete(); m_acc_ed.delete();
            end
        end
        cyc++;
    end

    // Stimulus
    logic [W-1:0] q_in0[$];
    logic [W-1:0] q_in1[$];
    logic [W:0]   q_out[$];

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] o);
        q_in0.push_back(a); q_in1.push_back(b); q_out.push_back(o);
    endtask

    task automatic start_run(input int n);
        @(posedge clk); #1;
        start = 1'b1; num_samples = NW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int gap_pct, input bit poke_start);
        bit acc;
        int guard = 0;
        while (q_in0.size() > 0 && guard < 3000) begin
            start = 1'b0;
            if (!if_a.s_valid && $urandom_range(99) >= gap_pct) begin
                if_a.s_in0 = q_in0[0]; if_a.s_in1 = q_in1[0]; if_a.s_out = q_out[0];
                if_a.s_valid = 1'b1;
            end
            if (poke_start && $urandom_range(15) == 0) begin
                start = 1'b1; num_samples = NW'($urandom_range(0, 7));
            end
            @(negedge clk);
            acc = if_a.s_valid && if_a.s_ready;
            @(posedge clk); #1;
            if (acc) begin
                void'(q_in0.pop_front()); void'(q_in1.pop_front()); void'(q_out.pop_front());
                if_a.s_valid = 1'b0;
            end
            guard++;
        end
        start = 1'b0;
        chk("feed_timeout", 64'(q_in0.size()), 64'd0);
        q_in0.delete(); q_in1.delete(); q_out.delete();
    endtask

    task automatic wait_done();
        int g = 0;
        while (!a_done && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("done_wait", 64'(a_done), 64'd1);
    endtask

    initial begin
        bit acc;
        int g;
        if_a.s_valid = 1'b0; if_a.s_in0 = '0; if_a.s_in1 = '0; if_a.s_out = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sd", 64'(a_sd), 64'd0);
        chk("rst_ready", 64'(if_a.s_ready), 64'd0);
        rst_n = 1'b1;

        // Exact adder results
        push(16'h0001, 16'h0002, 17'h00003);
        push(16'hFFFF, 16'hFFFF, 17'h1FFFE);
        push(16'h8000, 16'h8000, 17'h10000);
        push(16'h0000, 16'h0000, 17'h00000);
        start_run(4); feed(0, 1'b0); wait_done();
        chk("t1_err", 64'(a_err), 64'd0);
        chk("t1_max", 64'(a_max), 64'd0);
        chk("t1_sum", 64'(a_sum), 64'd0);
        chk("t1_sd",  64'(a_sd),  64'd4);

        // Known error distances 1, 0x1000, 2
        push(16'h00FF, 16'h0001, 17'h000FF);
        push(16'h1000, 16'h1000, 17'h03000);
        push(16'h0005, 16'h0005, 17'h0000C);
        start_run(3); feed(0, 1'b0); wait_done();
        chk("t2_err", 64'(a_err), 64'd3);
        chk("t2_max", 64'(a_max), 64'h1000);
        chk("t2_sum", 64'(a_sum), 64'h1003);

        // Handshake with toggling valid, then an extra sample that must stay pending
        start_run(2);
        for (int k = 0; k < 2; k++) begin
            if_a.s_in0 = 16'(k + 1); if_a.s_in1 = 16'h0010; if_a.s_out = 17'h00010;
            if_a.s_valid = 1'b1;
            acc = 1'b0; g = 0;
            while (!acc && g < 20) begin
                @(negedge clk);
                acc = if_a.s_valid && if_a.s_ready;
                @(posedge clk); #1;
                g++;
            end
            chk("hs_accept", 64'(acc), 64'd1);
            if_a.s_valid = 1'b0;
            if (k == 0) begin
                @(posedge clk); #1;
            end
        end
        chk("hs_ready_drop", 64'(if_a.s_ready), 64'd0);
        if_a.s_valid = 1'b1; if_a.s_in0 = 16'h0F0F;
        @(posedge clk); #1;
        chk("hs_done_early", 64'(a_done), 64'd0);
        @(posedge clk); #1;
        chk("hs_done_at2", 64'(a_done), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("hs_sd", 64'(a_sd), 64'd2);
        chk("hs_err", 64'(a_err), 64'd2);
        if_a.s_valid = 1'b0;

        // Zero-length run
        start_run(0);
        chk("z_done", 64'(a_done), 64'd1);
        chk("z_sd", 64'(a_sd), 64'd0);
        chk("z_err", 64'(a_err), 64'd0);

        // Saturation of the 17-bit accumulator
        repeat (3) push(16'hFFFF, 16'hFFFF, 17'h00000);
        start_run(3); feed(30, 1'b0); wait_done();
        chk("sat_sum_b", 64'(b_sum), 64'h1FFFF);
        chk("sat_max_b", 64'(b_max), 64'h1FFFE);
        chk("sat_sum_a", 64'(a_sum), 64'h5FFFA);

        // Reset after 2 of 5 accepts
        push(16'h0003, 16'h0004, 17'h00000);
        push(16'h0003, 16'h0004, 17'h00007);
        start_run(5); feed(0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mr_sd", 64'(a_sd), 64'd0);
        chk("mr_busy", 64'(a_busy), 64'd0);
        chk("mr_ready", 64'(if_a.s_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(16'h1234, 16'h0001, 17'h01235);
        start_run(1); feed(0, 1'b0); wait_done();
        chk("mr_sd2", 64'(a_sd), 64'd1);

        // Randomised runs
        for (int r = 0; r < 14; r++) begin
            int n;
            n = $urandom_range(0, 25);
            for (int i = 0; i < n; i++) begin
                logic [W-1:0] a, b;
                logic [W:0]   ex, o;
                a = W'($urandom); b = W'($urandom);
                ex = {1'b0, a} + {1'b0, b};
                case ($urandom_range(3))
                    0: o = ex;
                    1: o = ex ^ (17'd1 << $urandom_range(16));
                    2: o = (W+1)'($urandom);
                    default: o = ex + (W+1)'($urandom_range(0, 5)) - (W+1)'(2);
                endcase
                push(a, b, o);
            end
            start_run(n);
            feed($urandom_range(0, 60), 1'b1);
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
